// File: rtl/core_peripheral_bridge.sv
// Peripheral-side endpoint of one core: buffers core result words in a FWFT FIFO
// for a host, and forwards host words back to the core as single-cycle pulses.
module core_peripheral_bridge #(
  parameter int unsigned CORE       = 32'd0,
  parameter int unsigned DATA_WIDTH = 32'd32,
  parameter int unsigned DEPTH_BITS = 32'd3
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            core_out_channel,
  input  logic [DATA_WIDTH-1:0] core_out_data,
  input  logic                  core_out_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  output logic [1:0]            host_rx_channel,
  output logic [DATA_WIDTH-1:0] host_rx_data,
  output logic                  host_rx_valid,
  input  logic                  host_rx_ready,
  input  logic [1:0]            host_tx_channel,
  input  logic [DATA_WIDTH-1:0] host_tx_data,
  input  logic                  host_tx_valid,
  output logic                  host_tx_ready,
  output logic [DEPTH_BITS:0]   fifo_count,
  output logic                  overflow,
  output logic [15:0]           drop_count
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  typedef logic [DATA_WIDTH+1:0] entry_t;
  typedef enum logic [1:0] {TX_IDLE, TX_SEND, TX_GAP} tx_state_t;

  entry_t              mem_q [DEPTH];
  logic [DEPTH_BITS:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_BITS:0] rd_ptr_q, rd_ptr_d;
  logic                overflow_q, overflow_d;
  logic [15:0]         drop_count_q, drop_count_d;
  logic                full, empty, pop, push_ok, drop;
  entry_t              head;

  tx_state_t             tx_state_q;
  logic                  tx_ready_q;
  logic                  fp_valid_q;
  logic [1:0]            fp_channel_q;
  logic [DATA_WIDTH-1:0] fp_data_q;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty        = (wr_ptr_q == rd_ptr_q);
    full         = (wr_ptr_q[DEPTH_BITS] != rd_ptr_q[DEPTH_BITS]) &&
                   (wr_ptr_q[DEPTH_BITS-1:0] == rd_ptr_q[DEPTH_BITS-1:0]);
    pop          = !empty && host_rx_ready;
    push_ok      = core_out_valid && (!full || pop);
    drop         = core_out_valid && full && !pop;
    wr_ptr_d     = wr_ptr_q + {{DEPTH_BITS{1'b0}}, push_ok};
    rd_ptr_d     = rd_ptr_q + {{DEPTH_BITS{1'b0}}, pop};
    overflow_d   = overflow_q || drop;
    drop_count_d = drop_count_q;
    if (drop && (drop_count_q != 16'hFFFF)) begin
      drop_count_d = drop_count_q + 16'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // A push on a full FIFO with a pop overwrites the slot being read out this cycle.
  always_ff @(posedge clock) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[DEPTH_BITS-1:0]] <= {core_out_channel, core_out_data};
    end
  end

  assign head            = mem_q[rd_ptr_q[DEPTH_BITS-1:0]];
  assign host_rx_channel = head[DATA_WIDTH+1:DATA_WIDTH];
  assign host_rx_data    = head[DATA_WIDTH-1:0];
  assign host_rx_valid   = !empty;
  assign fifo_count      = wr_ptr_q - rd_ptr_q;
  assign overflow        = overflow_q;
  assign drop_count      = drop_count_q;

  // TX: one accepted host word yields a one-cycle pulse, then a one-cycle gap.
  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state_q   <= TX_IDLE;
      tx_ready_q   <= 1'b1;
      fp_valid_q   <= 1'b0;
      fp_channel_q <= 2'd0;
      fp_data_q    <= '0;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (host_tx_valid) begin
            tx_state_q   <= TX_SEND;
            tx_ready_q   <= 1'b0;
            fp_valid_q   <= 1'b1;
            fp_channel_q <= host_tx_channel;
            fp_data_q    <= host_tx_data;
          end
        end
        TX_SEND: begin
          tx_state_q <= TX_GAP;
          fp_valid_q <= 1'b0;
        end
        TX_GAP: begin
          tx_state_q <= TX_IDLE;
          tx_ready_q <= 1'b1;
        end
        default: begin
          tx_state_q <= TX_IDLE;
          tx_ready_q <= 1'b1;
          fp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign host_tx_ready         = tx_ready_q;
  assign from_peripheral_valid = fp_valid_q;
  assign from_peripheral       = fp_channel_q;
  assign from_peripheral_data  = fp_data_q;

`ifndef SYNTHESIS
  always_ff @(posedge clock) begin
    if (!reset && drop) begin
      $display("core_peripheral_bridge[%0d]: dropped core word 0x%h", CORE, core_out_data);
    end
  end
`endif

endmodule
